// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, widths and address-check helper for the data-memory responder
//
// Contents:
//   state_t   : responder FSM states (IDLE, WAIT, RESP)
//   WORD_W    : data word width in bits
//   BE_W      : number of byte lanes per word
//   addr_err  : 1 when a byte address is misaligned or outside [base, base + depth*4)

package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // The subtraction wraps for addresses below base, which is why the
  // explicit addr < base term is needed alongside the index bound.
  function automatic logic addr_err(
    input logic [WORD_W-1:0] addr,
    input logic [WORD_W-1:0] base,
    input int unsigned       depth
  );
    logic [WORD_W-1:0] word_off;
    word_off = (addr - base) >> 2;
    return (addr[1:0] != 2'b00) || (addr < base) || (word_off >= depth);
  endfunction

endpackage

// File: rtl/bemem.sv
// rtl/bemem.sv - byte-enabled word array, synchronous write and combinational read
//
// Ports:
//   clk    in   clock; writes land on the rising edge
//   we     in   write strobe for the addressed word
//   be     in   per-byte-lane write enables (lane i = bits [8i+7:8i])
//   idx    in   word index, shared by the read and write paths
//   wdata  in   write data
//   rdata  out  current contents of word idx (combinational)

module bemem
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int IDX_W       = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  // Contents are deliberately not reset; a load from a never-written word
  // returns whatever the storage powers up with.
  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) begin
          mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - load/store responder with valid/ready handshakes and fixed wait states
//
// Ports:
//   clk        in   single clock, rising-edge
//   reset      in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  responder idle and able to accept
//   req_we     in   1 = store, 0 = load
//   req_addr   in   byte address
//   req_wdata  in   store data
//   req_be     in   store byte enables (ignored on loads)
//   rsp_valid  out  response present
//   rsp_ready  in   requester takes the response
//   rsp_rdata  out  load data; 0 for stores and errored accesses
//   rsp_err    out  access was misaligned or out of range

module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int         IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT   = 4'(LATENCY);

  state_t state_q, state_d;

  logic [3:0]        cnt_q,   cnt_d;
  logic              we_q,    we_d;
  logic [WORD_W-1:0] addr_q,  addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q,    be_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              err_q,   err_d;

  logic              accept;
  logic              commit;
  logic              c_we;
  logic [WORD_W-1:0] c_addr;
  logic [WORD_W-1:0] c_wdata;
  logic [BE_W-1:0]   c_be;
  logic              c_err;
  logic [IDX_W-1:0]  c_idx;
  logic              mem_we;
  logic [WORD_W-1:0] mem_rdata;

  // Accept/commit decode and the commit-side operand mux.
  always_comb begin
    accept = (state_q == IDLE) && req_valid;

    case (state_q)
      IDLE:    commit = req_valid && (LAT == 4'd0);
      WAIT:    commit = (cnt_q == 4'd1);
      default: commit = 1'b0;
    endcase

    // With zero wait states the accept edge is also the commit edge, so the
    // operands come straight from the request port instead of the holding
    // registers (which only load on that same edge).
    if (state_q == IDLE) begin
      c_we    = req_we;
      c_addr  = req_addr;
      c_wdata = req_wdata;
      c_be    = req_be;
    end else begin
      c_we    = we_q;
      c_addr  = addr_q;
      c_wdata = wdata_q;
      c_be    = be_q;
    end

    c_err  = addr_err(c_addr, BASE_ADDR, DEPTH_WORDS);
    c_idx  = IDX_W'((c_addr - BASE_ADDR) >> 2);
    mem_we = commit && c_we && !c_err;
  end

  bemem #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_bemem (
    .clk   (clk),
    .we    (mem_we),
    .be    (c_be),
    .idx   (c_idx),
    .wdata (c_wdata),
    .rdata (mem_rdata)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = commit ? RESP : WAIT;
      WAIT:    if (commit) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
  end

  // Counter, holding registers and response registers.
  always_comb begin
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    if (accept) begin
      cnt_d   = LAT;
      we_d    = req_we;
      addr_d  = req_addr;
      wdata_d = req_wdata;
      be_d    = req_be;
    end else if ((state_q == WAIT) && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end

    if (commit) begin
      err_d   = c_err;
      rdata_d = (!c_we && !c_err) ? mem_rdata : '0;
    end else if ((state_q == RESP) && rsp_ready) begin
      err_d   = 1'b0;
      rdata_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed and randomized checks of dmem_responder at LATENCY 2 and 0
module tb_dmem_responder;

  localparam int          DEPTH = 64;
  localparam int          LAT_A = 2;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          NB    = 9;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        a_req_valid = 0, a_req_we = 0, a_rsp_ready = 0;
  logic [31:0] a_req_addr = 0, a_req_wdata = 0;
  logic [3:0]  a_req_be = 0;
  logic        a_req_ready, a_rsp_valid, a_rsp_err;
  logic [31:0] a_rsp_rdata;

  logic        b_req_valid = 0, b_req_we = 0, b_rsp_ready = 0;
  logic [31:0] b_req_addr = 0, b_req_wdata = 0;
  logic [3:0]  b_req_be = 0;
  logic        b_req_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rdata;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_A), .BASE_ADDR(BASE)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0), .BASE_ADDR(BASE)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] model  [DEPTH];
  logic [31:0] b_model[4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_err(input logic [31:0] a);
    return ((a % 4) != 0) || (a < BASE) || (((a - BASE) / 4) >= DEPTH);
  endfunction

  // One complete transaction on the LATENCY=2 instance, with the reference
  // model applied first and the response held for 'stall' extra cycles.
  task automatic txn_a(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int stall,
                       output logic [31:0] rd, output logic er);
    logic        exp_err;
    logic [31:0] exp_rd;
    int          idx;
    int          n;
    exp_err = m_err(addr);
    exp_rd  = 32'h0;
    if (!exp_err) begin
      idx = int'((addr - BASE) / 4);
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) model[idx][8*i +: 8] = wdata[8*i +: 8];
      end else begin
        exp_rd = model[idx];
      end
    end
    @(negedge clk);
    chk("a_ready_idle", a_req_ready, 1);
    a_req_valid = 1; a_req_we = we; a_req_addr = addr; a_req_wdata = wdata; a_req_be = be;
    @(posedge clk); #1;
    // Scramble the request port while busy; it must be ignored.
    a_req_valid = 1'($urandom); a_req_we = 1'($urandom);
    a_req_addr = $urandom; a_req_wdata = $urandom; a_req_be = 4'($urandom);
    n = 0;
    while (!a_rsp_valid && n < 40) begin
      chk("a_ready_busy", a_req_ready, 0);
      @(posedge clk); #1;
      n++;
    end
    chk("a_latency", n, LAT_A);
    chk("a_rsp_err", a_rsp_err, exp_err);
    chk("a_rsp_rdata", a_rsp_rdata, exp_rd);
    rd = a_rsp_rdata;
    er = a_rsp_err;
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      chk("a_hold_valid", a_rsp_valid, 1);
      chk("a_hold_ready", a_req_ready, 0);
      chk("a_hold_rdata", a_rsp_rdata, exp_rd);
      chk("a_hold_err", a_rsp_err, exp_err);
    end
    @(negedge clk);
    a_req_valid = 0;
    a_rsp_ready = 1;
    @(posedge clk); #1;
    a_rsp_ready = 0;
    chk("a_post_valid", a_rsp_valid, 0);
    chk("a_post_ready", a_req_ready, 1);
    chk("a_post_rdata", a_rsp_rdata, 0);
    chk("a_post_err", a_rsp_err, 0);
  endtask

  logic [31:0] rd, prior;
  logic        er;
  logic        b_we  [NB];
  logic [31:0] b_addr[NB], b_wd[NB], b_exp[NB];
  logic        b_eerr[NB];

  initial begin
    #2 reset = 0;
    #1;
    chk("rst_req_ready", a_req_ready, 1);
    chk("rst_rsp_valid", a_rsp_valid, 0);
    chk("rst_rsp_rdata", a_rsp_rdata, 0);
    chk("rst_rsp_err", a_rsp_err, 0);
    chk("rst0_req_ready", b_req_ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1;

    // Fill every word so later loads have defined expectations.
    for (int w = 0; w < DEPTH; w++)
      txn_a(1, BASE + 32'(4 * w), $urandom, 4'hF, 0, rd, er);

    // Full store then load.
    txn_a(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er);
    chk("store_rdata_zero", rd, 0);
    txn_a(0, 32'h10, 32'h0, 4'h0, 0, rd, er);
    chk("load_deadbeef", rd, 32'hDEADBEEF);

    // Partial store merges lanes 0 and 2.
    txn_a(1, 32'h10, 32'h11223344, 4'b0101, 0, rd, er);
    txn_a(0, 32'h10, 32'h0, 4'h0, 0, rd, er);
    chk("partial_merge", rd, 32'hDE22BE44);

    // Misaligned load and out-of-range store.
    txn_a(0, 32'h12, 32'h0, 4'h0, 0, rd, er);
    chk("misaligned_err", er, 1);
    prior = model[63];
    txn_a(1, 32'h100, 32'h5A5A5A5A, 4'hF, 0, rd, er);
    chk("oor_err", er, 1);
    txn_a(0, 32'h0FC, 32'h0, 4'h0, 0, rd, er);
    chk("oor_no_write", rd, prior);

    // be=0 store is a legal no-op.
    txn_a(1, 32'h14, 32'hFFFFFFFF, 4'h0, 0, rd, er);
    chk("be0_err", er, 0);
    txn_a(0, 32'h14, 32'h0, 4'h0, 0, rd, er);

    // Backpressure held for five cycles.
    txn_a(0, 32'h10, 32'h0, 4'h0, 5, rd, er);

    // Randomized traffic against the model.
    for (int t = 0; t < 80; t++) begin
      int          r;
      logic [31:0] ad;
      r = int'($urandom_range(0, 9));
      if (r < 7)       ad = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      else if (r == 7) ad = BASE + 32'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
      else             ad = $urandom;
      txn_a(1'($urandom), ad, $urandom, 4'($urandom), int'($urandom_range(0, 3)), rd, er);
    end

    // Reset while a store sits in WAIT: the store must be dropped.
    prior = model[8];
    @(negedge clk);
    a_req_valid = 1; a_req_we = 1; a_req_addr = 32'h20; a_req_wdata = 32'hCAFEF00D; a_req_be = 4'hF;
    @(posedge clk); #1;
    a_req_valid = 0;
    chk("rstw_in_wait", a_req_ready, 0);
    @(posedge clk); #2;
    reset = 0;
    #1;
    chk("rstw_req_ready", a_req_ready, 1);
    chk("rstw_rsp_valid", a_rsp_valid, 0);
    chk("rstw_rsp_rdata", a_rsp_rdata, 0);
    chk("rstw_rsp_err", a_rsp_err, 0);
    @(posedge clk);
    @(negedge clk) reset = 1;
    txn_a(0, 32'h20, 32'h0, 4'h0, 0, rd, er);
    chk("rstw_prior_kept", rd, prior);
    chk("rstw_not_cafe", rd === 32'hCAFEF00D, 0);

    // LATENCY=0 instance: back-to-back with rsp_ready tied high.
    for (int i = 0; i < 4; i++) begin
      b_model[i] = $urandom;
      b_we[i] = 1; b_addr[i] = 32'(4 * i); b_wd[i] = b_model[i]; b_exp[i] = 0; b_eerr[i] = 0;
      b_we[i+4] = 0; b_addr[i+4] = 32'(4 * i); b_wd[i+4] = $urandom; b_exp[i+4] = b_model[i]; b_eerr[i+4] = 0;
    end
    b_we[8] = 0; b_addr[8] = 32'h6; b_wd[8] = 0; b_exp[8] = 0; b_eerr[8] = 1;
    b_rsp_ready = 1;
    @(negedge clk);
    b_req_valid = 1; b_req_we = b_we[0]; b_req_addr = b_addr[0]; b_req_wdata = b_wd[0]; b_req_be = 4'hF;
    for (int i = 0; i < NB; i++) begin
      chk("b_ready_idle", b_req_ready, 1);
      @(posedge clk); #1;
      chk("b_rsp_valid", b_rsp_valid, 1);
      chk("b_ready_resp", b_req_ready, 0);
      chk("b_rsp_rdata", b_rsp_rdata, b_exp[i]);
      chk("b_rsp_err", b_rsp_err, b_eerr[i]);
      if (i + 1 < NB) begin
        b_req_we = b_we[i+1]; b_req_addr = b_addr[i+1]; b_req_wdata = b_wd[i+1];
      end else begin
        b_req_valid = 0;
      end
      @(posedge clk); #1;
      chk("b_post_valid", b_rsp_valid, 0);
      chk("b_post_rdata", b_rsp_rdata, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
